cgra_hbm_rd_dma: RTL and testbench
==================================

// Module: cgra_hbm_rd_dma
// PURPOSE
//  Parametrised AXI4 read DMA feeding CGRA input columns from HBM. Takes a base address and byte
//  count from the control plane, splits the transfer into 4KB-safe bursts with several in flight,
//  buffers read beats in a credit-reserved FIFO and streams them out to SIMD_DEG lanes with tlast.
//  Pulses interrupt when done. Generalises the fixed single-burst m00/m01/m02 readers to any width/depth.
// PARAMETERS
//  ADDR_W      64   byte address width (dwidth_HBMadd)
//  DATA_W      512  beat width in bits (phit_size); BYTES=DATA_W/8
//  SIMD_DEG    4    output lanes; per-lane tvalid/tready
//  MAX_BURST   16   max beats per AR burst (1..256)
//  MAX_OUTST   4    max AR bursts outstanding
//  FIFO_DEPTH  64   read-data FIFO depth in beats, power of 2, >= MAX_BURST
// PORTS
//  clk                     in   1         clock
//  rst                     in   1         async active-high reset
//  ctrl_start              in   1         1-cycle start pulse; ignored while ctrl_busy
//  ctrl_addr_offset        in   ADDR_W    base byte address, sampled on start
//  ctrl_xfer_size_in_bytes in   32        byte count, sampled on start
//  ctrl_busy               out  1         high from accepted start until final beat leaves
//  interrupt               out  1         1-cycle pulse after final beat handshake
//  m_axi_araddr            out  ADDR_W    burst address
//  m_axi_arlen             out  8         beats-1
//  m_axi_arvalid           out  1
//  m_axi_arready           in   1
//  m_axi_rdata             in   DATA_W
//  m_axi_rlast             in   1
//  m_axi_rvalid            in   1
//  m_axi_rready            out  1
//  axis_tdata              out  DATA_W
//  axis_tvalid             out  SIMD_DEG  all bits equal
//  axis_tready             in   SIMD_DEG  beat transfers only when all bits high (AND-reduce)
//  axis_tlast              out  1         high on final beat
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. rst mid-transfer aborts at once; in-flight
//   AXI bursts are abandoned (slave is reset with us).
//  FSM: IDLE -start,size>0-> ISSUE; IDLE -start,size==0-> DONE. ISSUE -last AR accepted-> DRAIN.
//   DRAIN -final beat out-> DONE. DONE -> IDLE (interrupt=1, busy=0 that cycle).
//  Beats: total=ceil(size/BYTES); addr low log2(BYTES) bits forced 0; a partial last beat is sent full.
//  Burst len = min(MAX_BURST, beats left, beats to next 4KB boundary); arlen=len-1.
//  AR issued only if outstanding<MAX_OUTST and free_credits>=len; credits reserved when AR is
//   accepted, returned when a beat leaves axis. AR held stable until arready.
//  m_axi_rready = 1 in ISSUE/DRAIN (credits guarantee space); outstanding decrements on rvalid&rlast.
//  FIFO write same cycle as R handshake; read-to-axis latency 1 cycle (registered output).
//  Simultaneous AR accept and rlast: outstanding unchanged. Simultaneous push/pop at full: allowed.
//  tlast asserted on beat number total-1 of the stream; rresp not checked.
// CONFIGURATION
//  CGRA_DMA_CYCLE_CNT_EN defined: adds output ctrl_cycle_cnt [31:0], cleared on accepted start,
//   +1 each busy cycle, holds after DONE, saturates at 0xFFFFFFFF. Undefined: port and counter absent.
// STRUCTURE
//  cgra_dma_pkg: dma_state_t enum {IDLE,ISSUE,DRAIN,DONE}, BOUNDARY_4K constant, function
//   beats_to_4k(addr), function ceil_beats(size).
//  Sub-module cgra_sync_fifo (DATA_W x FIFO_DEPTH, full/empty/count, async rst).
// TESTING (DATA_W=512, BYTES=64, defaults otherwise)
//  addr 0x0, size 4096, tready=1 -> 4 ARs arlen=15 at 0x0,0x400,0x800,0xC00; 64 beats; tlast on 64th; 1 interrupt.
//  addr 0xFC0, size 256 -> AR 0xFC0 arlen=0, then 0x1000 arlen=2; 4 beats in order.
//  size 100, addr 0x43 -> single AR 0x40 arlen=1; 2 beats, tlast on 2nd.
//  size 0 -> no arvalid; interrupt pulse within 2 cycles of start; busy low after.
//  size 8192, tready=0 -> arvalid stops after 4 bursts (64 credits); no rdata lost; release -> 128 beats exact.
//  rst asserted mid-transfer -> next cycle all outputs 0, FSM IDLE; new start runs cleanly.

Source files
------------

// File: rtl/cgra_dma_pkg.sv
// Shared types and helpers for the CGRA HBM read DMA: FSM state encoding,
// the 4KB AXI boundary, and beat-count arithmetic used when splitting bursts.
package cgra_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

  // Whole beats between a beat-aligned address and the next 4KB boundary.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo,
                                              input int unsigned byte_shift);
    logic [12:0] rem;
    rem = BOUNDARY_4K - {1'b0, addr_lo};
    return rem >> byte_shift;
  endfunction

  // Beats needed to cover size bytes; a trailing partial beat counts as one.
  function automatic logic [31:0] ceil_beats(input logic [31:0] size,
                                             input int unsigned byte_shift);
    logic [32:0] sum;
    sum = {1'b0, size} + ((33'd1 << byte_shift) - 33'd1);
    return 32'(sum >> byte_shift);
  endfunction

endpackage

// File: rtl/cgra_sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry; a push is
// accepted at full when a pop happens in the same cycle.
module cgra_sync_fifo #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en_s, rd_en_s;

  always_comb begin
    rd_en_s  = pop_i && (count_q != '0);
    wr_en_s  = push_i && ((count_q != FULL_CNT) || pop_i);
    wr_ptr_d = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_en_s) - (AW+1)'(rd_en_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cgra_hbm_rd_dma.sv
// AXI4 read DMA: splits a byte transfer into 4KB-safe bursts, buffers beats in a
// credit-reserved FIFO and streams them to SIMD lanes. Define CGRA_DMA_CYCLE_CNT_EN for ctrl_cycle_cnt.
module cgra_hbm_rd_dma
  import cgra_dma_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned SIMD_DEG   = 4,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl_start,
  input  logic [ADDR_W-1:0]   ctrl_addr_offset,
  input  logic [31:0]         ctrl_xfer_size_in_bytes,
  output logic                ctrl_busy,
  output logic                interrupt,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [DATA_W-1:0]   axis_tdata,
  output logic [SIMD_DEG-1:0] axis_tvalid,
  input  logic [SIMD_DEG-1:0] axis_tready,
  output logic                axis_tlast
`ifdef CGRA_DMA_CYCLE_CNT_EN
  ,
  output logic [31:0]         ctrl_cycle_cnt
`endif
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BSH   = $clog2(BYTES);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW    = $clog2(MAX_OUTST + 1);

  dma_state_t        state_q, state_d;
  logic [31:0]       total_q, total_d, left_q, left_d, load_idx_q, load_idx_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              arvalid_q, arvalid_d;
  logic [8:0]        issue_len_q, issue_len_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     used_q, used_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              ar_hs_s, r_hs_s, axis_hs_s, fifo_pop_s, can_issue_s, rready_s;
  logic              fifo_empty_s, fifo_full_s, fifo_unused_s;
  logic [CW-1:0]     fifo_count_s, free_s;
  logic [DATA_W-1:0] fifo_rdata_s;
  logic [31:0]       to4k_s, len_a_s, burst_len_s;

  assign rready_s      = (state_q == ISSUE) || (state_q == DRAIN);
  assign fifo_unused_s = ^{fifo_full_s, fifo_count_s};

  cgra_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (r_hs_s),
    .wdata_i (m_axi_rdata),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  always_comb begin
    to4k_s      = 32'(beats_to_4k(next_addr_q[11:0], BSH));
    len_a_s     = (left_q < 32'(MAX_BURST)) ? left_q : 32'(MAX_BURST);
    burst_len_s = (to4k_s < len_a_s) ? to4k_s : len_a_s;
    free_s      = CW'(FIFO_DEPTH) - used_q;
    ar_hs_s     = arvalid_q && m_axi_arready;
    r_hs_s      = m_axi_rvalid && rready_s;
    axis_hs_s   = out_valid_q && (&axis_tready);
    fifo_pop_s  = !fifo_empty_s && (!out_valid_q || axis_hs_s);
    // Credits were checked when the AR was loaded; they can only grow until it is accepted.
    can_issue_s = (state_q == ISSUE) && !arvalid_q && (left_q != 32'd0) &&
                  (outst_q < OW'(MAX_OUTST)) && (32'(free_s) >= burst_len_s);
  end

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    left_d      = left_q;
    load_idx_d  = load_idx_q;
    next_addr_d = next_addr_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arvalid_d   = arvalid_q;
    issue_len_d = issue_len_q;
    outst_d     = outst_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    used_d      = used_q + (ar_hs_s ? CW'(issue_len_q) : CW'(0)) - (axis_hs_s ? CW'(1) : CW'(0));

    case ({ar_hs_s, r_hs_s && m_axi_rlast})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    if (fifo_pop_s) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_rdata_s;
      out_last_d  = (load_idx_q == total_q - 32'd1);
      load_idx_d  = load_idx_q + 32'd1;
    end else if (axis_hs_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          total_d     = ceil_beats(ctrl_xfer_size_in_bytes, BSH);
          left_d      = ceil_beats(ctrl_xfer_size_in_bytes, BSH);
          next_addr_d = ctrl_addr_offset & ~ADDR_W'(BYTES - 1);
          load_idx_d  = 32'd0;
          state_d     = (ctrl_xfer_size_in_bytes == 32'd0) ? DONE : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (can_issue_s) begin
          arvalid_d   = 1'b1;
          araddr_d    = next_addr_q;
          arlen_d     = 8'(burst_len_s - 32'd1);
          issue_len_d = 9'(burst_len_s);
          next_addr_d = next_addr_q + (ADDR_W'(burst_len_s) << BSH);
          left_d      = left_q - burst_len_s;
        end else if (ar_hs_s) begin
          arvalid_d = 1'b0;
          state_d   = (left_q == 32'd0) ? DRAIN : ISSUE;
        end else begin
          arvalid_d = arvalid_q;
        end
      end
      DRAIN: begin
        if (axis_hs_s && out_last_q) state_d = DONE;
        else                         state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      total_q     <= 32'd0;
      left_q      <= 32'd0;
      load_idx_q  <= 32'd0;
      next_addr_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= 8'd0;
      arvalid_q   <= 1'b0;
      issue_len_q <= 9'd0;
      outst_q     <= '0;
      used_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      left_q      <= left_d;
      load_idx_q  <= load_idx_d;
      next_addr_q <= next_addr_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arvalid_q   <= arvalid_d;
      issue_len_q <= issue_len_d;
      outst_q     <= outst_d;
      used_q      <= used_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ctrl_busy     = rready_s;
  assign interrupt     = (state_q == DONE);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_s;
  assign axis_tdata    = out_data_q;
  assign axis_tvalid   = {SIMD_DEG{out_valid_q}};
  assign axis_tlast    = out_last_q;

`ifdef CGRA_DMA_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if ((state_q == IDLE) && ctrl_start) begin
      cyc_cnt_d = 32'd0;
    end else if (rready_s && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end else begin
      cyc_cnt_d = cyc_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_cnt_q <= 32'd0;
    else     cyc_cnt_q <= cyc_cnt_d;
  end

  assign ctrl_cycle_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_cgra_hbm_rd_dma.sv
// Bench for cgra_hbm_rd_dma: directed and randomized transfers against an AXI
// slave model and a burst-splitting reference computed from plain arithmetic.
module tb_cgra_hbm_rd_dma;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ctrl_start = 1'b0;
  logic [63:0]  ctrl_addr_offset = 64'd0;
  logic [31:0]  ctrl_xfer_size_in_bytes = 32'd0;
  logic         ctrl_busy, interrupt;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic         m_axi_arvalid;
  logic         m_axi_arready = 1'b0;
  logic [511:0] m_axi_rdata = '0;
  logic         m_axi_rlast = 1'b0;
  logic         m_axi_rvalid = 1'b0;
  logic         m_axi_rready;
  logic [511:0] axis_tdata;
  logic [3:0]   axis_tvalid;
  logic [3:0]   axis_tready = 4'h0;
  logic         axis_tlast;

  typedef struct { logic [63:0] addr; int len; } ar_t;
  ar_t          slv_q[$];
  ar_t          ar_log[$];
  logic [512:0] beat_log[$];

  int     vectors = 0, errs = 0, irq_cnt = 0, arv_cnt = 0, rbeat = 0;
  int     tmode = 1, smode = 0;
  longint cyc = 0, irq_cyc = 0, start_cyc = 0;
  logic   r_hs_prev = 1'b0;

  cgra_hbm_rd_dma dut (
    .clk                     (clk),
    .rst                     (rst),
    .ctrl_start              (ctrl_start),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_busy               (ctrl_busy),
    .interrupt               (interrupt),
    .m_axi_araddr            (m_axi_araddr),
    .m_axi_arlen             (m_axi_arlen),
    .m_axi_arvalid           (m_axi_arvalid),
    .m_axi_arready           (m_axi_arready),
    .m_axi_rdata             (m_axi_rdata),
    .m_axi_rlast             (m_axi_rlast),
    .m_axi_rvalid            (m_axi_rvalid),
    .m_axi_rready            (m_axi_rready),
    .axis_tdata              (axis_tdata),
    .axis_tvalid             (axis_tvalid),
    .axis_tready             (axis_tready),
    .axis_tlast              (axis_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] mem_word(input logic [63:0] a);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 * 32'(i + 1));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI slave, AXIS sink and event monitors; everything is decided away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        slv_q.delete();
        rbeat        = 0;
        r_hs_prev    = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_arready = 1'b0;
      end else begin
        if (r_hs_prev) begin
          if (rbeat >= slv_q[0].len) begin
            void'(slv_q.pop_front());
            rbeat = 0;
          end else begin
            rbeat++;
          end
        end
        if (!(m_axi_rvalid && !r_hs_prev)) begin
          if (slv_q.size() > 0 && (smode == 0 || $urandom_range(0, 3) != 0)) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = mem_word(slv_q[0].addr + 64'(rbeat) * 64'd64);
            m_axi_rlast  = (rbeat == slv_q[0].len);
          end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
          end
        end
        r_hs_prev = m_axi_rvalid && m_axi_rready;

        m_axi_arready = (smode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (m_axi_arvalid) arv_cnt++;
        if (m_axi_arvalid && m_axi_arready) begin
          slv_q.push_back('{m_axi_araddr, int'(m_axi_arlen)});
          ar_log.push_back('{m_axi_araddr, int'(m_axi_arlen)});
        end
      end
      case (tmode)
        0:       axis_tready = 4'h0;
        1:       axis_tready = 4'hF;
        default: axis_tready = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      endcase
      if ((&axis_tvalid) && (&axis_tready)) beat_log.push_back({axis_tlast, axis_tdata});
      if (interrupt) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    ar_log.delete();
    beat_log.delete();
    irq_cnt = 0;
    arv_cnt = 0;
  endtask

  task automatic start_xfer(input logic [63:0] addr, input logic [31:0] size);
    @(negedge clk);
    ctrl_addr_offset        = addr;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start              = 1'b1;
    start_cyc               = cyc;
    @(negedge clk);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_irq();
    int n = 0;
    while (irq_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_xfer(input string tag, input logic [63:0] addr, input longint size);
    logic [63:0] base, a;
    longint total, left, len, to4k;
    int idx;
    base  = addr & ~64'h3F;
    a     = base;
    total = (size + 63) / 64;
    left  = total;
    idx   = 0;
    while (left > 0) begin
      to4k = (4096 - longint'(a % 4096)) / 64;
      len  = (left < 16) ? left : 16;
      if (to4k < len) len = to4k;
      if (idx < ar_log.size()) begin
        chk({tag, "_araddr"}, 576'(ar_log[idx].addr), 576'(a));
        chk({tag, "_arlen"}, 576'(ar_log[idx].len), 576'(len - 1));
      end
      a    = a + 64'(len * 64);
      left = left - len;
      idx++;
    end
    chk({tag, "_ar_count"}, 576'(ar_log.size()), 576'(idx));
    chk({tag, "_beat_count"}, 576'(beat_log.size()), 576'(total));
    for (int i = 0; i < beat_log.size() && i < total; i++) begin
      chk({tag, "_beat"}, 576'(beat_log[i]),
          576'({(longint'(i) == total - 1), mem_word(base + 64'(i) * 64'd64)}));
    end
    chk({tag, "_irq_count"}, 576'(irq_cnt), 576'(1));
    chk({tag, "_busy_after"}, 576'(ctrl_busy), 576'(0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, 576'({m_axi_arvalid, m_axi_rready, axis_tvalid, axis_tlast, ctrl_busy, interrupt}), 576'(0));
    chk({tag, "_ar"}, 576'({m_axi_araddr, m_axi_arlen}), 576'(0));
    chk({tag, "_tdata"}, 576'(axis_tdata), 576'(0));
  endtask

  initial begin
    logic [63:0] raddr;
    logic [31:0] rsize;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset_released");

    tmode = 1; smode = 0;
    clear_logs();
    start_xfer(64'h0, 32'd4096);
    wait_irq();
    check_xfer("x4k", 64'h0, 4096);

    clear_logs();
    start_xfer(64'hFC0, 32'd256);
    wait_irq();
    check_xfer("cross4k", 64'hFC0, 256);

    clear_logs();
    start_xfer(64'h43, 32'd100);
    wait_irq();
    check_xfer("partial", 64'h43, 100);

    clear_logs();
    start_xfer(64'h1000, 32'd0);
    repeat (4) @(negedge clk);
    chk("zero_arvalid", 576'(arv_cnt), 576'(0));
    chk("zero_irq", 576'(irq_cnt), 576'(1));
    chk("zero_irq_latency_le2", 576'((irq_cyc - start_cyc) <= 2), 576'(1));
    chk("zero_busy", 576'(ctrl_busy), 576'(0));

    clear_logs();
    tmode = 0;
    start_xfer(64'h0, 32'd8192);
    repeat (300) @(negedge clk);
    chk("stall_ar_count", 576'(ar_log.size()), 576'(4));
    chk("stall_beats", 576'(beat_log.size()), 576'(0));
    chk("stall_irq", 576'(irq_cnt), 576'(0));
    chk("stall_busy", 576'(ctrl_busy), 576'(1));
    tmode = 1;
    wait_irq();
    check_xfer("stall", 64'h0, 8192);

    tmode = 2; smode = 1;
    for (int k = 0; k < 4; k++) begin
      raddr = 64'($urandom_range(0, 32'h3FFFF));
      rsize = (k == 0) ? 32'($urandom_range(1024, 3000)) : 32'($urandom_range(1, 3000));
      clear_logs();
      start_xfer(raddr, rsize);
      if (k == 0) begin
        repeat (3) @(negedge clk);
        if (ctrl_busy) start_xfer(64'h5000, 32'd64);
      end
      wait_irq();
      check_xfer("rand", raddr, longint'(rsize));
    end

    tmode = 1; smode = 0;
    clear_logs();
    start_xfer(64'h0, 32'd4096);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    start_xfer(64'h2000, 32'd512);
    wait_irq();
    check_xfer("after_rst", 64'h2000, 512);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
